// File: rtl/s2m_fifo_drain_if.sv
// s2m_fifo_drain_if: PE FIFO read side plus master-memory write port of the s2m drain.
interface s2m_fifo_drain_if #(
  parameter int NUM_PE    = 4,
  parameter int DEPTH_PE  = 2,
  parameter int WIDTH_D   = 16,
  parameter int DEPTH_V_F = 16
);
  logic [NUM_PE-1:0]                     fifo_req_r;
  logic [NUM_PE-1:0]                     fifo_valid;
  logic [NUM_PE*(WIDTH_D+DEPTH_V_F)-1:0] fifo_r_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DEPTH_V_F-1:0]                  out_addr;
  logic [WIDTH_D-1:0]                    out_data;
  logic [DEPTH_PE-1:0]                   out_core;
  modport master (
    output fifo_req_r, out_valid, out_addr, out_data, out_core,
    input  fifo_valid, fifo_r_data, out_ready
  );
  modport slave (
    input  fifo_req_r, out_valid, out_addr, out_data, out_core,
    output fifo_valid, fifo_r_data, out_ready
  );
endinterface

// File: rtl/s2m_fifo_drain.sv
// s2m_fifo_drain: round-robin reader of per-PE s2m FIFOs feeding a valid/ready write port.
module s2m_fifo_drain #(
  parameter int NUM_PE      = 4,
  parameter int DEPTH_PE    = 2,
  parameter int WIDTH_D     = 16,
  parameter int DEPTH_V_F   = 16,
  parameter int WAIT_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  s2m_fifo_drain_if.master bus
);
  localparam int W = WIDTH_D + DEPTH_V_F;
  typedef enum logic [1:0] {SCAN, WAIT, OUT} state_t;
  state_t               state_q, state_d;
  logic [DEPTH_PE-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_PE-1:0]    req_q, req_d;
  logic                 valid_q, valid_d;
  logic [DEPTH_V_F-1:0] addr_q, addr_d;
  logic [WIDTH_D-1:0]   data_q, data_d;
  logic [DEPTH_PE-1:0]  core_q, core_d;
  logic [W-1:0]         entry;
  logic                 hit, timeout;
  assign entry   = bus.fifo_r_data[ptr_q*W +: W];
  assign hit     = bus.fifo_valid[ptr_q];
  assign timeout = cnt_q == 8'(WAIT_CYCLES - 1);
  assign ptr_nxt = (ptr_q == DEPTH_PE'(NUM_PE - 1)) ? '0 : ptr_q + DEPTH_PE'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      core_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      core_q  <= core_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    state_d = WAIT;
      WAIT:    state_d = hit ? OUT : timeout ? SCAN : WAIT;
      OUT:     state_d = bus.out_ready ? SCAN : OUT;
      default: state_d = SCAN;
    endcase
  end
  // req is only set from SCAN, so it drops after the first WAIT cycle by default
  always_comb begin
    req_d   = '0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    core_d  = core_q;
    if (state_q == SCAN) begin
      req_d = NUM_PE'(1) << ptr_q;
      cnt_d = '0;
    end
    if (state_q == WAIT) begin
      if (hit) begin
        valid_d = 1'b1;
        addr_d  = entry[W-1:WIDTH_D];
        data_d  = entry[WIDTH_D-1:0];
        core_d  = ptr_q;
      end else if (timeout) begin
        ptr_d = ptr_nxt;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (state_q == OUT && bus.out_ready) begin
      valid_d = 1'b0;
      ptr_d   = ptr_nxt;
    end
  end
  assign bus.fifo_req_r = req_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_data   = data_q;
  assign bus.out_core   = core_q;
endmodule
